// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with optional two-entry skid buffer.
// Moves a payload from producer to consumer under valid/ready handshakes.
// With SKID=1, in_ready comes straight from a flop, which cuts the stall
// path from out_ready back to the producer.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   flush               - synchronous flush; drops held and incoming payloads
//   in_valid/in_ready   - producer handshake; in_data is the producer payload
//   out_valid/out_ready - consumer handshake; out_data is the consumer payload
//   occupancy           - number of valid entries held (0..2)
//   stall_cnt           - saturating count of out_valid & ~out_ready cycles
module pipe_skid_reg #(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter bit                SKID       = 1'b1,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              m_vld, s_vld;
    logic [DATA_W-1:0] m_dat, s_dat;
    logic              m_vld_n, s_vld_n;
    logic [DATA_W-1:0] m_dat_n, s_dat_n;
    logic              in_fire, out_fire;

    assign out_valid = m_vld;
    assign out_data  = m_dat;
    assign occupancy = 2'(m_vld) + 2'(s_vld);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_vld & out_ready;

    // Registered ready with skid slot; combinational pass-through otherwise.
    generate
        if (SKID) begin : g_skid_rdy
            assign in_ready = ~s_vld;
        end else begin : g_reg_rdy
            assign in_ready = ~m_vld | out_ready;
        end
    endgenerate

    // Next-state for the storage slots; state is implied by {m_vld, s_vld}.
    always_comb begin
        m_vld_n = m_vld;
        m_dat_n = m_dat;
        s_vld_n = s_vld;
        s_dat_n = s_dat;
        if (SKID) begin
            if (!m_vld) begin
                // empty
                if (in_fire) begin
                    m_vld_n = 1'b1;
                    m_dat_n = in_data;
                end
            end else if (!s_vld) begin
                // one entry
                if (in_fire && out_fire) begin
                    m_dat_n = in_data;
                end else if (in_fire) begin
                    s_vld_n = 1'b1;
                    s_dat_n = in_data;
                end else if (out_fire) begin
                    m_vld_n = 1'b0;
                    m_dat_n = RESET_DATA;
                end
            end else begin
                // full: skid entry moves up once main drains
                if (out_fire) begin
                    m_dat_n = s_dat;
                    s_vld_n = 1'b0;
                    s_dat_n = RESET_DATA;
                end
            end
        end else begin
            if (in_fire) begin
                m_vld_n = 1'b1;
                m_dat_n = in_data;
            end else if (out_fire) begin
                m_vld_n = 1'b0;
                m_dat_n = RESET_DATA;
            end
        end
    end

    // State update; flush clears the slots but leaves the stall counter alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_vld     <= 1'b0;
            s_vld     <= 1'b0;
            m_dat     <= RESET_DATA;
            s_dat     <= RESET_DATA;
            stall_cnt <= '0;
        end else if (flush) begin
            m_vld     <= 1'b0;
            s_vld     <= 1'b0;
            m_dat     <= RESET_DATA;
            s_dat     <= RESET_DATA;
        end else begin
            m_vld <= m_vld_n;
            s_vld <= s_vld_n;
            m_dat <= m_dat_n;
            s_dat <= s_dat_n;
            if (m_vld && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a SKID=1 instance (a_*) and a SKID=0, CNT_W=4
// instance with a non-zero bubble value (b_*), each with a FIFO scoreboard.
module tb_pipe_skid_reg;

    localparam int unsigned DW  = 64;
    localparam logic [DW-1:0] NOP = 64'h0000_0000_0000_0013;

    logic clk = 1'b0;
    logic reset;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occ;
    logic [15:0]   a_stall;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occ;
    logic [3:0]    b_stall;

    logic [DW-1:0] a_q[$];
    logic [DW-1:0] b_q[$];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .SKID(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_skid_reg #(.DATA_W(DW), .RESET_DATA(NOP), .SKID(1'b0), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard sampling at the falling edge, then advance to just past the rising edge.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        if (reset || a_flush) a_q.delete();
        else begin
            if (a_out_valid && a_out_ready) begin
                e = 'x;
                if (a_q.size() != 0) e = a_q.pop_front();
                chk("a_sb_data", a_out_data, e);
            end
            if (a_in_valid && a_in_ready) a_q.push_back(a_in_data);
        end
        if (reset || b_flush) b_q.delete();
        else begin
            if (b_out_valid && b_out_ready) begin
                e = 'x;
                if (b_q.size() != 0) e = b_q.pop_front();
                chk("b_sb_data", b_out_data, e);
            end
            if (b_in_valid && b_in_ready) b_q.push_back(b_in_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d[3];
        d[0] = 64'hAAAA_0000_0000_0001;
        d[1] = 64'hBBBB_0000_0000_0002;
        d[2] = 64'hCCCC_0000_0000_0003;

        reset = 1'b1;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("a_rst_valid", 64'(a_out_valid), 64'd0);
        chk("a_rst_data",  a_out_data, 64'd0);
        chk("a_rst_occ",   64'(a_occ), 64'd0);
        chk("a_rst_ready", 64'(a_in_ready), 64'd1);
        chk("a_rst_stall", 64'(a_stall), 64'd0);
        chk("b_rst_data",  b_out_data, NOP);
        chk("b_rst_ready", 64'(b_in_ready), 64'd1);

        // first transaction, one-cycle latency
        a_in_valid = 1; a_in_data = 64'h00003000_3C010001; a_out_ready = 1;
        tick();
        a_in_valid = 0;
        chk("a_t1_valid", 64'(a_out_valid), 64'd1);
        chk("a_t1_data",  a_out_data, 64'h00003000_3C010001);
        chk("a_t1_occ",   64'(a_occ), 64'd1);
        tick();
        chk("a_t1_occ_drain", 64'(a_occ), 64'd0);
        chk("a_t1_empty_data", a_out_data, 64'd0);

        // back-to-back stream, no bubbles
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1; a_in_data = d[i];
            tick();
            chk("a_str_ready", 64'(a_in_ready), 64'd1);
            chk("a_str_valid", 64'(a_out_valid), 64'd1);
            chk("a_str_data",  a_out_data, d[i]);
        end
        a_in_valid = 0;
        tick();
        chk("a_str_occ", 64'(a_occ), 64'd0);

        // fill the skid slot, order preserved on release
        a_out_ready = 0; a_in_valid = 1; a_in_data = d[0];
        tick();
        chk("a_sk_occ1", 64'(a_occ), 64'd1);
        a_in_data = d[1];
        tick();
        chk("a_sk_occ2",  64'(a_occ), 64'd2);
        chk("a_sk_rdy0",  64'(a_in_ready), 64'd0);
        chk("a_sk_head",  a_out_data, d[0]);
        chk("a_sk_stall1", 64'(a_stall), 64'd1);
        a_in_data = d[2];   // ignored while in_ready=0
        tick();
        chk("a_sk_hold_occ", 64'(a_occ), 64'd2);
        chk("a_sk_stall2",   64'(a_stall), 64'd2);
        a_in_valid = 0; a_out_ready = 1;
        tick();
        chk("a_sk_next", a_out_data, d[1]);
        chk("a_sk_occ_back", 64'(a_occ), 64'd1);
        chk("a_sk_rdy1", 64'(a_in_ready), 64'd1);
        tick();
        chk("a_sk_drained", 64'(a_occ), 64'd0);
        chk("a_sk_stall_keep", 64'(a_stall), 64'd2);

        // flush while full with in_valid high
        a_out_ready = 0; a_in_valid = 1; a_in_data = d[0];
        tick();
        a_in_data = d[1];
        tick();
        chk("a_fl_pre_occ", 64'(a_occ), 64'd2);
        a_flush = 1; a_in_data = d[2];
        tick();
        a_flush = 0; a_in_valid = 0;
        chk("a_fl_valid", 64'(a_out_valid), 64'd0);
        chk("a_fl_data",  a_out_data, 64'd0);
        chk("a_fl_occ",   64'(a_occ), 64'd0);
        chk("a_fl_ready", 64'(a_in_ready), 64'd1);
        chk("a_fl_stall", 64'(a_stall), 64'd3);
        tick();
        chk("a_fl_discard", 64'(a_out_valid), 64'd0);

        // SKID=0: combinational in_ready and simultaneous replace
        b_out_ready = 0; b_in_valid = 1; b_in_data = d[0];
        tick();
        chk("b_full_occ",   64'(b_occ), 64'd1);
        chk("b_full_rdy0",  64'(b_in_ready), 64'd0);
        chk("b_full_stall", 64'(b_stall), 64'd0);
        b_out_ready = 1; b_in_data = d[1];
        #1;
        chk("b_rdy_comb", 64'(b_in_ready), 64'd1);
        tick();
        chk("b_rep_occ",  64'(b_occ), 64'd1);
        chk("b_rep_data", b_out_data, d[1]);

        // saturating 4-bit stall counter
        b_in_valid = 0; b_out_ready = 0;
        repeat (14) tick();
        chk("b_stall14", 64'(b_stall), 64'd14);
        repeat (6) tick();
        chk("b_stall_sat", 64'(b_stall), 64'd15);
        b_out_ready = 1;
        tick();
        chk("b_drain_occ",   64'(b_occ), 64'd0);
        chk("b_drain_data",  b_out_data, NOP);
        chk("b_drain_stall", 64'(b_stall), 64'd15);

        reset = 1;
        tick();
        reset = 0;
        tick();
        chk("b_rst2_stall", 64'(b_stall), 64'd0);
        chk("a_rst2_stall", 64'(a_stall), 64'd0);
        chk("a_sb_left", 64'(a_q.size()), 64'd0);
        chk("b_sb_left", 64'(b_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
